// File: rtl/mfp_gpio_arbiter.sv
// mfp_gpio_arbiter: round-robin arbiter giving N_REQ requesters shared access
// to a bank of 32-bit GPIO registers, one transaction at a time.
//   HCLK, HRESET            : clock, synchronous active-high reset
//   req_valid/write/lock    : per-requester request, direction, keep-grant
//   req_addr, req_wdata     : per-requester register index and write data
//   req_ready               : accept strobe (combinational, IDLE only)
//   rsp_valid, rsp_rdata    : completion strobe and registered read data
//   rsp_err                 : address out of range for the operation
//   gpio_rd                 : GPIO read registers
//   gpio_wd, gpio_we        : GPIO write data and one-hot write strobe
module mfp_gpio_arbiter #(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned GPIO_W = 1,
    parameter int unsigned GPIO_R = GPIO_W,
    localparam int unsigned GPIO_MAX = (GPIO_W > GPIO_R) ? GPIO_W : GPIO_R,
    localparam int unsigned AW = (GPIO_MAX > 1) ? $clog2(GPIO_MAX) : 1
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ-1:0]              req_write,
    input  logic [N_REQ-1:0]              req_lock,
    input  logic [N_REQ-1:0][AW-1:0]      req_addr,
    input  logic [N_REQ-1:0][31:0]        req_wdata,
    output logic [N_REQ-1:0]              req_ready,
    output logic [N_REQ-1:0]              rsp_valid,
    output logic [31:0]                   rsp_rdata,
    output logic                          rsp_err,
    input  logic [GPIO_R-1:0][31:0]       gpio_rd,
    output logic [31:0]                   gpio_wd,
    output logic [GPIO_W-1:0]             gpio_we
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     owner_q;
    logic              lock_q;
    logic              wr_q;
    logic [AW-1:0]     addr_q;
    logic [31:0]       wdata_q;

    logic [N_REQ-1:0]  elig_c;
    logic              found_c;
    logic [IW-1:0]     win_c;
    logic [IW-1:0]     ptr_nxt_c;
    int unsigned       k_c;
    logic              accept_c;
    logic [31:0]       rd_sel_c;
    logic              err_c;

    // Round-robin search upward from ptr; a held lock masks everyone but its owner.
    always_comb begin
        elig_c  = lock_q ? (req_valid & (N_REQ'(1) << owner_q)) : req_valid;
        found_c = 1'b0;
        win_c   = '0;
        k_c     = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            k_c = 32'(ptr_q) + i;
            if (k_c >= N_REQ) begin
                k_c = k_c - N_REQ;
            end
            if (!found_c && elig_c[IW'(k_c)]) begin
                found_c = 1'b1;
                win_c   = IW'(k_c);
            end
        end
    end

    assign accept_c  = (state_q == S_IDLE) && found_c;
    assign ptr_nxt_c = (32'(win_c) == N_REQ - 1) ? '0 : win_c + IW'(1);

    // Read-data mux; out-of-range indices fall through to zero.
    always_comb begin
        rd_sel_c = '0;
        for (int i = 0; i < GPIO_R; i++) begin
            if (addr_q == AW'(i)) begin
                rd_sel_c = gpio_rd[i];
            end
        end
    end

    assign err_c   = wr_q ? (32'(addr_q) >= GPIO_W) : (32'(addr_q) >= GPIO_R);
    assign gpio_wd = wdata_q;

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (found_c) state_d = S_ACCESS;
            S_ACCESS: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_err   = 1'b0;
        gpio_we   = '0;
        case (state_q)
            S_IDLE: begin
                if (found_c) req_ready[win_c] = 1'b1;
            end
            S_ACCESS: begin
                for (int i = 0; i < GPIO_W; i++) begin
                    if (addr_q == AW'(i)) gpio_we[i] = wr_q;
                end
            end
            S_DONE: begin
                rsp_valid[owner_q] = 1'b1;
                rsp_err            = err_c;
            end
            default: ;
        endcase
    end

    // Transaction capture, lock tracking and read-data register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ptr_q     <= '0;
            owner_q   <= '0;
            lock_q    <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
        end else begin
            if (accept_c) begin
                ptr_q   <= ptr_nxt_c;
                owner_q <= win_c;
                lock_q  <= req_lock[win_c];
                wr_q    <= req_write[win_c];
                addr_q  <= req_addr[win_c];
                wdata_q <= req_wdata[win_c];
            end
            if (state_q == S_ACCESS) begin
                rsp_rdata <= wr_q ? '0 : rd_sel_c;
            end
        end
    end

endmodule

// File: tb/tb_mfp_gpio_arbiter.sv
// tb_mfp_gpio_arbiter: directed bench for mfp_gpio_arbiter with N_REQ=2,
// GPIO_W=2, GPIO_R=3 (AW=2, so both out-of-range addresses are reachable).
module tb_mfp_gpio_arbiter;

    logic             HCLK = 1'b0;
    logic             HRESET;
    logic [1:0]       req_valid;
    logic [1:0]       req_write;
    logic [1:0]       req_lock;
    logic [1:0][1:0]  req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic [2:0][31:0] gpio_rd;
    logic [31:0]      gpio_wd;
    logic [1:0]       gpio_we;

    int total = 0;
    int bad   = 0;

    mfp_gpio_arbiter #(.N_REQ(2), .GPIO_W(2), .GPIO_R(3)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .gpio_rd   (gpio_rd),
        .gpio_wd   (gpio_wd),
        .gpio_we   (gpio_we)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        int          r;
        logic        wr;
        logic [1:0]  a;
        logic [31:0] d;
        logic [1:0]  we;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Waits (bounded) for any grant, sampled mid-cycle; returns 0 on timeout.
    task automatic wait_grant(output logic [1:0] g);
        g = 2'b00;
        for (int i = 0; i < 20; i++) begin
            @(negedge HCLK);
            if (req_ready != 2'b00) begin
                g = req_ready;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge HCLK); #1;
        HRESET    = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_gpio_we", 32'(gpio_we), 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
    endtask

    // Single transaction from one requester, checked at k, k+1, k+2.
    task automatic do_txn(input vec_t v);
        logic [1:0] g;
        logic [1:0] exp_oh;
        exp_oh = 2'b01 << v.r;
        @(posedge HCLK); #1;
        req_valid[v.r] = 1'b1;
        req_write[v.r] = v.wr;
        req_lock[v.r]  = 1'b0;
        req_addr[v.r]  = v.a;
        req_wdata[v.r] = v.d;
        wait_grant(g);
        chk("txn_ready", 32'(g), 32'(exp_oh));
        @(posedge HCLK); #1;
        req_valid[v.r] = 1'b0;
        @(negedge HCLK);
        chk("txn_gpio_we", 32'(gpio_we), 32'(v.we));
        chk("txn_gpio_wd", gpio_wd, v.d);
        chk("txn_early_rsp", 32'(rsp_valid), 32'h0);
        @(negedge HCLK);
        chk("txn_rsp_valid", 32'(rsp_valid), 32'(exp_oh));
        chk("txn_rdata", rsp_rdata, v.rd);
        chk("txn_err", 32'(rsp_err), 32'(v.err));
        chk("txn_we_done", 32'(gpio_we), 32'h0);
    endtask

    // Reset asserted during the ACCESS cycle; nothing may follow from the aborted txn.
    task automatic abort_in_access();
        @(posedge HCLK); #1;
        req_valid = '0;
        HRESET    = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            chk("abort_gpio_we", 32'(gpio_we), 32'h0);
            chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
        end
    endtask

    initial begin
        logic [1:0] g;
        logic [1:0] gr[4];
        int         at[4];
        int         n;

        HRESET    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_wdata = '0;
        gpio_rd[0] = 32'h1234_5678;
        gpio_rd[1] = 32'hCAFE_0001;
        gpio_rd[2] = 32'hDEAD_0002;

        //           r  wr    a     d               we     rd              err
        vecs[0] = '{0, 1'b1, 2'd0, 32'hA5A5_0001, 2'b01, 32'h0,          1'b0};
        vecs[1] = '{0, 1'b0, 2'd0, 32'h0000_0000, 2'b00, 32'h1234_5678,  1'b0};
        vecs[2] = '{1, 1'b1, 2'd1, 32'h0000_BEEF, 2'b10, 32'h0,          1'b0};
        vecs[3] = '{1, 1'b0, 2'd2, 32'h0000_0003, 2'b00, 32'hDEAD_0002,  1'b0};
        vecs[4] = '{1, 1'b1, 2'd2, 32'h0BAD_0002, 2'b00, 32'h0,          1'b1};
        vecs[5] = '{0, 1'b0, 2'd1, 32'h0000_0005, 2'b00, 32'hCAFE_0001,  1'b0};
        vecs[6] = '{0, 1'b0, 2'd3, 32'h0000_0006, 2'b00, 32'h0,          1'b1};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            do_txn(vecs[i]);
        end

        // Two readers held from reset: grants alternate every 3 cycles.
        do_reset();
        req_write = '0;
        req_addr  = '0;
        req_valid = 2'b11;
        n = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge HCLK);
            if (req_ready != 2'b00) begin
                gr[n] = req_ready;
                at[n] = cyc;
                n++;
                if (n == 4) break;
            end
        end
        chk("rr_count", 32'(n), 32'd4);
        chk("rr_g0", 32'(gr[0]), 32'h1);
        chk("rr_g1", 32'(gr[1]), 32'h2);
        chk("rr_g2", 32'(gr[2]), 32'h1);
        chk("rr_g3", 32'(gr[3]), 32'h2);
        chk("rr_first_at", 32'(at[0]), 32'd0);
        for (int i = 1; i < 4; i++) begin
            chk("rr_spacing", 32'(at[i] - at[i-1]), 32'd3);
        end

        // Lock held by req1 across a read-modify-write while req0 keeps asking.
        do_reset();
        do_txn(vecs[1]);
        @(posedge HCLK); #1;
        req_write = 2'b00;
        req_lock  = 2'b10;
        req_addr[0] = 2'd1;
        req_addr[1] = 2'd2;
        req_valid = 2'b11;
        n = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge HCLK);
            if (req_ready != 2'b00) begin
                gr[n] = req_ready;
                at[n] = cyc;
                n++;
                @(posedge HCLK); #1;
                if (n == 1) begin
                    req_write[1] = 1'b1;
                    req_lock[1]  = 1'b0;
                    req_addr[1]  = 2'd0;
                    req_wdata[1] = 32'h5555_AAAA;
                end else if (n == 2) begin
                    req_valid[1] = 1'b0;
                end else begin
                    req_valid[0] = 1'b0;
                    break;
                end
            end
        end
        chk("lock_count", 32'(n), 32'd3);
        chk("lock_g0", 32'(gr[0]), 32'h2);
        chk("lock_g1", 32'(gr[1]), 32'h2);
        chk("lock_g2", 32'(gr[2]), 32'h1);
        chk("lock_gap", 32'(at[1] - at[0]), 32'd3);
        @(negedge HCLK);
        @(negedge HCLK);
        chk("lock_r0_rsp", 32'(rsp_valid), 32'h1);
        chk("lock_r0_rdata", rsp_rdata, 32'hCAFE_0001);

        // Reset during ACCESS of a write moved ptr to 1; afterwards req0 must win.
        do_reset();
        @(posedge HCLK); #1;
        req_write[0] = 1'b1;
        req_lock[0]  = 1'b0;
        req_addr[0]  = 2'd1;
        req_wdata[0] = 32'h7777_0000;
        req_valid    = 2'b01;
        wait_grant(g);
        chk("abort1_grant", 32'(g), 32'h1);
        abort_in_access();
        @(posedge HCLK); #1;
        req_write = 2'b00;
        req_addr[0] = 2'd0;
        req_addr[1] = 2'd1;
        req_valid = 2'b11;
        wait_grant(g);
        chk("abort1_ptr_reset", 32'(g), 32'h1);
        @(posedge HCLK); #1;
        req_valid = '0;
        @(negedge HCLK);
        @(negedge HCLK);
        chk("abort1_rsp", 32'(rsp_valid), 32'h1);
        chk("abort1_rdata", rsp_rdata, 32'h1234_5678);

        // Reset during ACCESS of a locked write by req1; lock must be gone.
        @(posedge HCLK); #1;
        req_write[1] = 1'b1;
        req_lock[1]  = 1'b1;
        req_addr[1]  = 2'd0;
        req_wdata[1] = 32'h0F0F_0F0F;
        req_valid    = 2'b10;
        wait_grant(g);
        chk("abort2_grant", 32'(g), 32'h2);
        abort_in_access();
        @(posedge HCLK); #1;
        req_lock     = 2'b00;
        req_write[0] = 1'b0;
        req_addr[0]  = 2'd2;
        req_valid    = 2'b01;
        wait_grant(g);
        chk("abort2_lock_clear", 32'(g), 32'h1);
        @(posedge HCLK); #1;
        req_valid = '0;
        @(negedge HCLK);
        @(negedge HCLK);
        chk("abort2_rsp", 32'(rsp_valid), 32'h1);
        chk("abort2_rdata", rsp_rdata, 32'hDEAD_0002);
        chk("abort2_err", 32'(rsp_err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
